// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared by the ALU/load requesters, decode scoreboard port
// and the register-file write port. WB_BYPASS_EN adds the forwarding signals.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // requester A: single-cycle ALU path
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  // requester B: multi-cycle load/mul path
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  // decode scoreboard set and hazard queries
  logic              sb_set;
  logic [ADDR_W-1:0] sb_rd;
  logic [ADDR_W-1:0] q_rs1;
  logic [ADDR_W-1:0] q_rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  // register-file write port
  logic              WE3;
  logic [ADDR_W-1:0] AD3;
  logic [DATA_W-1:0] WD3;
`ifdef WB_BYPASS_EN
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // writeback sources, decode and the register file
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output sb_set, sb_rd, q_rs1, q_rs2,
    input  a_ready, b_ready, rs1_busy, rs2_busy, WE3, AD3, WD3
`ifdef WB_BYPASS_EN
    , input fwd1_hit, fwd2_hit, fwd_data
`endif
  );

  // the arbiter
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  sb_set, sb_rd, q_rs1, q_rs2,
    output a_ready, b_ready, rs1_busy, rs2_busy, WE3, AD3, WD3
`ifdef WB_BYPASS_EN
    , output fwd1_hit, fwd2_hit, fwd_data
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with busy scoreboard.
// A (ALU) has priority over B (load/mul) except when B has been denied
// STARVE_MAX consecutive cycles. The write port is driven from registers.
// Optional macro WB_BYPASS_EN: forwards the staged write to decode.

// One scoreboard bit. Set dominates clear so a re-issue landing on the
// commit edge keeps the hazard alive.
module regfile_wb_sb_cell (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic busy_o
);
  logic busy_q, busy_d;

  // next busy state: set wins over clear
  always_comb busy_d = set_i | (busy_q & ~clr_i);

  // busy bit register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= 1'b0;
    else      busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = 4;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              starved;
  logic              grant_a, grant_b, xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0]   busy;
  logic [NREG-1:1]   set_vec, clr_vec;
  logic              hit1, hit2;

  // arbitration: A first unless B has hit the starvation limit; quiet in reset
  always_comb begin
    starved = (starve_q == CNT_W'(STARVE_MAX));
    grant_b = rst & bus.b_valid & (~bus.a_valid | starved);
    grant_a = rst & bus.a_valid & ~grant_b;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // starvation count: grows while B waits, cleared by a B grant or B idle
  always_comb begin
    starve_d = starve_q;
    if (!bus.b_valid || grant_b) starve_d = '0;
    else if (!starved)           starve_d = starve_q + 1'b1;
  end

  // stage the granted write; x0 writes are accepted but never enabled
  always_comb begin
    xfer     = grant_a | grant_b;
    sel_rd   = grant_b ? bus.b_rd   : bus.a_rd;
    sel_data = grant_b ? bus.b_data : bus.a_data;
    we_d     = xfer & (sel_rd != '0);
    ad_d     = we_d ? sel_rd   : ad_q;
    wd_d     = we_d ? sel_data : wd_q;
  end

  // write-port and starvation registers; reset drops any staged write
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      ad_q     <= '0;
      wd_q     <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      ad_q     <= ad_d;
      wd_q     <= wd_d;
      starve_q <= starve_d;
    end
  end

  assign bus.WE3 = we_q;
  assign bus.AD3 = ad_q;
  assign bus.WD3 = wd_q;

  // scoreboard: x0 is never busy; a bit clears only when the register
  // file actually commits, so decode never sees a stale read
  assign busy[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_sb
    assign set_vec[i] = bus.sb_set & (bus.sb_rd == ADDR_W'(i));
    assign clr_vec[i] = we_q & (ad_q == ADDR_W'(i));
    regfile_wb_sb_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .set_i  (set_vec[i]),
      .clr_i  (clr_vec[i]),
      .busy_o (busy[i])
    );
  end

`ifdef WB_BYPASS_EN
  // a committing write can feed decode directly, hiding its hazard
  assign hit1         = we_q & (ad_q != '0) & (ad_q == bus.q_rs1);
  assign hit2         = we_q & (ad_q != '0) & (ad_q == bus.q_rs2);
  assign bus.fwd1_hit = hit1;
  assign bus.fwd2_hit = hit2;
  assign bus.fwd_data = wd_q;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign bus.rs1_busy = busy[bus.q_rs1] & ~hit1;
  assign bus.rs2_busy = busy[bus.q_rs2] & ~hit2;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters. Requester A is the single-cycle ALU path; requester B is the multi-cycle load/mul path. A per-register busy scoreboard gives decode the hazard status of rs1/rs2. The block sits between the writeback sources and registerfile, and drives its write port from registered outputs.

Parameters:
STARVE_MAX, 4, consecutive cycles B may be denied while valid before B is forced to win (range 1..15)
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
a_valid  in  1  ALU writeback request
a_rd  in  ADDR_W  ALU destination register
a_data  in  DATA_W  ALU result
a_ready  out  1  grant to A; transfer when a_valid & a_ready
b_valid  in  1  load/mul writeback request
b_rd  in  ADDR_W  load/mul destination register
b_data  in  DATA_W  load/mul result
b_ready  out  1  grant to B; transfer when b_valid & b_ready
sb_set  in  1  decode issued an instruction that writes sb_rd
sb_rd  in  ADDR_W  destination register being marked busy
q_rs1  in  ADDR_W  hazard query address 1
q_rs2  in  ADDR_W  hazard query address 2
rs1_busy  out  1  busy[q_rs1], combinational
rs2_busy  out  1  busy[q_rs2], combinational
WE3  out  1  registered write enable to registerfile
AD3  out  ADDR_W  registered write address
WD3  out  DATA_W  registered write data

Behaviour:
- Reset (rst=0 at a posedge): WE3=0, AD3=0, WD3=0, all busy bits=0, starve counter=0. a_ready/b_ready read 0 while rst=0. Reset mid-transfer drops any staged write; no write to the register file occurs on that edge.
- Arbitration is combinational in the same cycle:
  - Only one of A/B valid: it gets ready=1.
  - Both valid: A wins, unless starve_cnt == STARVE_MAX, in which case B wins.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle. A ready never depends on a requester's own ready.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle b_valid=1 and b_ready=0.
  - Clears on any B transfer, or on any cycle b_valid=0.
- Output stage, 1-cycle latency:
  - On a transfer with rd != 0: WE3<=1, AD3<=rd, WD3<=data at the next edge.
  - On a transfer with rd == 0: accepted (ready=1), but WE3<=0 and AD3/WD3 hold.
  - No transfer: WE3<=0, AD3/WD3 hold their last values.
  - Back-to-back transfers every cycle are supported; no bubbles.
- Scoreboard:
  - 32 busy bits. busy[0] is hardwired 0; sb_set with sb_rd=0 is ignored.
  - Set: at the edge where sb_set=1, busy[sb_rd]<=1.
  - Clear: at the edge where WE3=1 (the cycle registerfile commits), busy[AD3]<=0.
  - The bit stays 1 while the write is only staged, so decode never reads a stale RD1/RD2.
  - Same register set and cleared on one edge: set wins, bit stays 1.
  - rs1_busy/rs2_busy read busy[] combinationally; a query of x0 returns 0.
- Both requesters may target the same rd in successive cycles. Writes commit in grant order; the last grant wins.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd_data (DATA_W).
  - fwdN_hit=1 when WE3=1, AD3 != 0 and AD3 == q_rsN.
  - fwd_data=WD3.
  - rsN_busy is forced to 0 when fwdN_hit=1, so decode can consume the staged value one cycle early.
- Not defined: these ports are absent. rsN_busy equals busy[q_rsN] exactly as above.

Test Plan:
- Reset: hold rst=0 for 2 cycles while a_valid=1, a_rd=5 -> a_ready=0, WE3=0, AD3=0, WD3=0, rs1_busy=0 for q_rs1=5.
- Single write: a_valid=1, a_rd=3, a_data=0x12345678 for one cycle -> a_ready=1 that cycle; next cycle WE3=1, AD3=3, WD3=0x12345678; following cycle WE3=0.
- Contention/starvation (STARVE_MAX=4): a_valid and b_valid held high, distinct rd -> A granted 4 cycles, B granted on cycle 5, then A again. The WE3 stream is A,A,A,A,B,A with no gaps.
- Scoreboard: sb_set=1, sb_rd=7; 3 cycles later a B transfer with b_rd=7 -> rs1_busy (q_rs1=7) is 1 from the edge after the set through the cycle WE3=1, and 0 the cycle after. Repeat with sb_set for rd 7 on the commit edge -> busy stays 1.
- x0: a_valid=1, a_rd=0, a_data=0xFFFFFFFF -> a_ready=1, WE3 stays 0; sb_set with sb_rd=0 -> rs1_busy=0 for q_rs1=0.
- WB_BYPASS_EN build: A writes rd=9, data 0xCAFE0001, q_rs1=9 -> in the WE3=1 cycle fwd1_hit=1, fwd_data=0xCAFE0001, rs1_busy=0.
